// File: rtl/eleven_bit_serializer_if.sv
// rtl/eleven_bit_serializer_if.sv - parallel-load / serial-out handshake bundle
interface eleven_bit_serializer_if;
   logic [10:0] in;
   logic        load;
   logic        hold;
   logic        ready;
   logic        sout;
   logic        sout_valid;
   logic        last;
   logic        done;

   modport master (output in, load, hold,
                   input  ready, sout, sout_valid, last, done);
   modport slave  (input  in, load, hold,
                   output ready, sout, sout_valid, last, done);
endinterface

// File: rtl/eleven_bit_serializer.sv
// rtl/eleven_bit_serializer.sv - 11-bit word serializer with stall, last and done pulse
module eleven_bit_serializer #(
   parameter bit LSB_FIRST = 1'b1
) (
   input logic                     CLK,
   input logic                     clear,
   eleven_bit_serializer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, next_state;
   logic [10:0] sreg;
   logic [3:0]  cnt;

   always_ff @(posedge CLK or posedge clear) begin
      if (clear) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.load) next_state = SHIFT;
         SHIFT:   if (!bus.hold && cnt == 4'd10) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Counter saturates at 10; it is re-zeroed on the next accepted load.
   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         sreg <= 11'd0;
         cnt  <= 4'd0;
      end else begin
         case (state)
            IDLE: if (bus.load) begin
               sreg <= bus.in;
               cnt  <= 4'd0;
            end
            SHIFT: if (!bus.hold) begin
               sreg <= LSB_FIRST ? {1'b0, sreg[10:1]} : {sreg[9:0], 1'b0};
               if (cnt != 4'd10) cnt <= cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.ready      = 1'b0;
      bus.sout       = 1'b0;
      bus.sout_valid = 1'b0;
      bus.last       = 1'b0;
      bus.done       = 1'b0;
      case (state)
         IDLE:  bus.ready = 1'b1;
         SHIFT: begin
            bus.sout_valid = 1'b1;
            bus.sout       = LSB_FIRST ? sreg[0] : sreg[10];
            bus.last       = (cnt == 4'd10);
         end
         DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_eleven_bit_serializer.sv
// tb/tb_eleven_bit_serializer.sv - directed bench for both bit orders of the serializer
module tb_eleven_bit_serializer;

   logic CLK = 1'b0;
   logic clear;
   int   checks = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   eleven_bit_serializer_if ifl ();
   eleven_bit_serializer_if ifm ();

   eleven_bit_serializer #(.LSB_FIRST(1'b1)) dut_lsb (.CLK(CLK), .clear(clear), .bus(ifl.slave));
   eleven_bit_serializer #(.LSB_FIRST(1'b0)) dut_msb (.CLK(CLK), .clear(clear), .bus(ifm.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [10:0] w, input logic ld, input logic hd);
      ifl.in = w;  ifl.load = ld;  ifl.hold = hd;
      ifm.in = w;  ifm.load = ld;  ifm.hold = hd;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready_l"}, ifl.ready, 1);
      check({tag, "_ready_m"}, ifm.ready, 1);
      check({tag, "_valid"},   {ifl.sout_valid, ifm.sout_valid}, 0);
      check({tag, "_sout"},    {ifl.sout, ifm.sout}, 0);
      check({tag, "_last"},    {ifl.last, ifm.last}, 0);
      check({tag, "_done"},    {ifl.done, ifm.done}, 0);
   endtask

   // seq_l / seq_m: bit k is the k-th emitted bit of each instance.
   task automatic send_word(input logic [10:0] w, input logic [10:0] seq_l,
                            input logic [10:0] seq_m, input int hold_at,
                            input int hold_len, input bit poke_load);
      int k = 0, held = 0, cyc = 0, nvalid = 0;
      logic hd;
      check("accept_ready", {ifl.ready, ifm.ready}, 2'b11);
      drive(w, 1'b1, 1'b0);
      step();
      cyc = 1;
      drive(w, 1'b0, 1'b0);
      while (k < 11 && cyc < 40) begin
         check("sout_l", ifl.sout, seq_l[k]);
         check("sout_m", ifm.sout, seq_m[k]);
         check("valid", {ifl.sout_valid, ifm.sout_valid}, 2'b11);
         check("last", {ifl.last, ifm.last}, (k == 10) ? 2'b11 : 2'b00);
         check("busy_ready", {ifl.ready, ifm.ready, ifl.done, ifm.done}, 0);
         hd = (k == hold_at && held < hold_len);
         if (hd) held++;
         else begin
            k++;
            nvalid++;
         end
         drive(w, 1'b0, hd);
         if (poke_load && k == 5 && !hd) drive(11'h001, 1'b1, 1'b0);
         step();
         cyc++;
      end
      drive(w, 1'b0, 1'b0);
      check("nvalid", nvalid, 11);
      check("done_cyc", cyc, 12 + hold_len);
      check("done_l", ifl.done, 1);
      check("done_m", ifm.done, 1);
      check("done_ready", {ifl.ready, ifm.ready, ifl.sout_valid, ifm.sout_valid}, 0);
      step();
      check_idle("post_done");
   endtask

   initial begin
      int ndone, first_done, last_done, nvalid;
      clear = 1'b1;
      drive(11'h000, 1'b0, 1'b0);
      #2;
      check_idle("reset");
      step();
      step();
      clear = 1'b0;

      // hold and load-free idle: nothing should start
      drive(11'h5A3, 1'b0, 1'b1);
      step();
      check_idle("idle_hold");
      drive(11'h5A3, 1'b0, 1'b0);

      send_word(11'h5A3, 11'h5A3, 11'h62D, 99, 0, 1'b0);
      send_word(11'h7FF, 11'h7FF, 11'h7FF, 3, 3, 1'b0);
      send_word(11'h5A3, 11'h5A3, 11'h62D, 99, 0, 1'b1);
      step();
      check_idle("no_second_word");

      // abort mid-word with asynchronous clear between edges
      drive(11'h5A3, 1'b1, 1'b0);
      step();
      drive(11'h5A3, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step();
      check("bit6_l", ifl.sout, 1'b0);
      check("bit6_m", ifm.sout, 1'b0);
      check("bit6_valid", {ifl.sout_valid, ifm.sout_valid}, 2'b11);
      #2 clear = 1'b1;
      #1;
      check_idle("async_clear");
      step();
      clear = 1'b0;
      check_idle("clear_released");
      send_word(11'h3FF, 11'h3FF, 11'h7FE, 99, 0, 1'b0);

      // continuous load: back-to-back words
      ndone = 0; first_done = 0; last_done = 0; nvalid = 0;
      drive(11'h5A3, 1'b1, 1'b0);
      for (int c = 1; c <= 26; c++) begin
         step();
         if (ifl.done) begin
            ndone++;
            if (first_done == 0) first_done = c;
            last_done = c;
         end
         if (ifl.sout_valid) nvalid++;
         if (c == 25) drive(11'h5A3, 1'b0, 1'b0);
      end
      check("b2b_ndone", ndone, 2);
      check("b2b_first_done", first_done, 12);
      check("b2b_spacing", last_done - first_done, 13);
      check("b2b_nvalid", nvalid, 22);
      check_idle("b2b_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
